// File: rtl/sisc_mem_responder_if.sv
// -----------------------------------------------------------------------------
// sisc_mem_responder_if
// Bundles the boot-load stream, the CPU request channel and the response
// channel of the SISC memory responder.
//
// Handshake rule (all three channels): a transfer happens on a rising clock
// edge where both valid and ready are high. Ready may depend on state only,
// never on valid.
//
// Signals:
//   load_valid/load_data/load_last -> load_ready : boot image stream
//   boot_done                                    : image loaded, CPU port live
//   req_valid/req_we/req_addr/req_wdata -> req_ready : CPU access request
//   rsp_valid/rsp_rdata -> rsp_ready             : response to the CPU
// Modports: slave = responder side, master = boot loader / CPU side.
// -----------------------------------------------------------------------------
interface sisc_mem_responder_if #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
);
  logic                load_valid;
  logic [WIDTH-1:0]    load_data;
  logic                load_last;
  logic                load_ready;
  logic                boot_done;
  logic                req_valid;
  logic                req_we;
  logic [ADDRSIZE-1:0] req_addr;
  logic [WIDTH-1:0]    req_wdata;
  logic                req_ready;
  logic                rsp_valid;
  logic [WIDTH-1:0]    rsp_rdata;
  logic                rsp_ready;

  modport slave (
    input  load_valid, load_data, load_last,
    input  req_valid, req_we, req_addr, req_wdata,
    input  rsp_ready,
    output load_ready, boot_done, req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output load_valid, load_data, load_last,
    output req_valid, req_we, req_addr, req_wdata,
    output rsp_ready,
    input  load_ready, boot_done, req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sisc_mem_responder.sv
// -----------------------------------------------------------------------------
// sisc_mem_responder
// Word-addressed program/data memory for the SISC CPU. After reset it accepts
// the program image as a stream (BOOT), then serves one CPU request at a time:
// writes answer one cycle after accept with an echo of the stored word, reads
// answer exactly RD_LAT cycles after accept (RD_LAT legal range 1..15).
// Array contents survive reset.
//
// Ports:
//   clk, reset    : single clock, synchronous active-high reset
//   bus (slave)   : load / request / response channels, see the interface
//   o_dbg_state   : current FSM state (0 BOOT, 1 IDLE, 2 RD_WAIT, 3 RESP)
// -----------------------------------------------------------------------------
module sisc_mem_responder #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12,
  parameter int RD_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sisc_mem_responder_if.slave  bus,
  output logic [1:0]           o_dbg_state
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [3:0]          LAT_M1   = 4'(RD_LAT - 1);
  localparam logic [ADDRSIZE-1:0] LAST_PTR = {ADDRSIZE{1'b1}};

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  logic [WIDTH-1:0]    r_mem [DEPTH];

  state_t              r_state, w_state_nxt;
  logic [ADDRSIZE-1:0] r_load_ptr, w_load_ptr_nxt;
  logic [ADDRSIZE-1:0] r_addr, w_addr_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]    r_rsp_rdata, w_rsp_rdata_nxt;

  logic                w_mem_we;
  logic [ADDRSIZE-1:0] w_mem_waddr;
  logic [WIDTH-1:0]    w_mem_wdata;
  logic [ADDRSIZE-1:0] w_mem_raddr;
  logic [WIDTH-1:0]    w_mem_rdata;

  logic                w_load_ready;
  logic                w_req_ready;
  logic                w_rsp_valid;

  // In IDLE the read port looks at the live request (RD_LAT=1 path); in
  // RD_WAIT it looks at the captured address.
  assign w_mem_raddr = (r_state == ST_IDLE) ? bus.req_addr : r_addr;
  assign w_mem_rdata = r_mem[w_mem_raddr];

  always_comb begin
    w_state_nxt     = r_state;
    w_load_ptr_nxt  = r_load_ptr;
    w_addr_nxt      = r_addr;
    w_cnt_nxt       = r_cnt;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_mem_we        = 1'b0;
    w_mem_waddr     = r_load_ptr;
    w_mem_wdata     = bus.load_data;
    w_load_ready    = 1'b0;
    w_req_ready     = 1'b0;
    w_rsp_valid     = 1'b0;

    case (r_state)
      ST_BOOT: begin
        w_load_ready = 1'b1;
        if (bus.load_valid) begin
          w_mem_we       = 1'b1;
          w_mem_waddr    = r_load_ptr;
          w_mem_wdata    = bus.load_data;
          w_load_ptr_nxt = r_load_ptr + ADDRSIZE'(1);
          // A full image ends boot even without load_last; the pointer
          // wraps to 0 and no further words are taken.
          if (bus.load_last || (r_load_ptr == LAST_PTR)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.req_we) begin
            w_mem_we        = 1'b1;
            w_mem_waddr     = bus.req_addr;
            w_mem_wdata     = bus.req_wdata;
            w_rsp_rdata_nxt = bus.req_wdata;
            w_state_nxt     = ST_RESP;
          end else begin
            w_addr_nxt = bus.req_addr;
            w_cnt_nxt  = LAT_M1;
            if (RD_LAT == 1) begin
              w_rsp_rdata_nxt = w_mem_rdata;
              w_state_nxt     = ST_RESP;
            end else begin
              w_state_nxt = ST_RD_WAIT;
            end
          end
        end
      end

      ST_RD_WAIT: begin
        // The counter reaches 0 on the same edge that enters RESP, which
        // makes accept-to-rsp_valid exactly RD_LAT edges.
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt       = 4'd0;
          w_rsp_rdata_nxt = w_mem_rdata;
          w_state_nxt     = ST_RESP;
        end
      end

      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_BOOT;
      r_load_ptr  <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_ptr  <= w_load_ptr_nxt;
      r_addr      <= w_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  // Array has no reset; reset only blocks a write that coincides with it.
  always_ff @(posedge clk) begin
    if (w_mem_we && !reset) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.boot_done  = (r_state != ST_BOOT);
  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sisc_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_sisc_mem_responder
// Directed bench for sisc_mem_responder (RD_LAT=2). Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_sisc_mem_responder;
  localparam int WIDTH    = 32;
  localparam int ADDRSIZE = 12;

  localparam logic [1:0] S_BOOT    = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  sisc_mem_responder_if #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) bus ();

  sisc_mem_responder #(
    .WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .RD_LAT(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read with rsp_ready already high: checks the 2-cycle latency, the data,
  // and the return to IDLE after the response is consumed.
  task automatic rd(input logic [ADDRSIZE-1:0] a, input logic [WIDTH-1:0] e, input string tag);
    logic [WIDTH-1:0] exp_v;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    exp_q.push_back(e);
    step();
    bus.req_valid = 1'b0;
    chk({tag, "_wait"}, {31'b0, bus.rsp_valid}, 32'd0);
    step();
    chk({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
    exp_v = exp_q.pop_front();
    chk({tag, "_data"}, bus.rsp_rdata, exp_v);
    step();
    chk({tag, "_idle"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [WIDTH-1:0] held;
    reset          = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    step();
    step();

    // reset state
    chk("rst_state",      {30'b0, dbg_state},       {30'b0, S_BOOT});
    chk("rst_boot_done",  {31'b0, bus.boot_done},   32'd0);
    chk("rst_load_ready", {31'b0, bus.load_ready},  32'd1);
    chk("rst_req_ready",  {31'b0, bus.req_ready},   32'd0);
    chk("rst_rsp_valid",  {31'b0, bus.rsp_valid},   32'd0);
    chk("rst_rsp_rdata",  bus.rsp_rdata,            32'd0);

    // boot three words, last flagged on the third
    reset          = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'h4000_1000;
    step();
    bus.load_data  = 32'h1000_0005;
    step();
    chk("boot_mid_done", {31'b0, bus.boot_done}, 32'd0);
    bus.load_data  = 32'h9000_0000;
    bus.load_last  = 1'b1;
    step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk("boot_done",       {31'b0, bus.boot_done},  32'd1);
    chk("boot_load_ready", {31'b0, bus.load_ready}, 32'd0);
    chk("boot_state",      {30'b0, dbg_state},      {30'b0, S_IDLE});

    // reads of the boot image
    bus.rsp_ready = 1'b1;
    rd(12'd1, 32'h1000_0005, "rd1");
    rd(12'd0, 32'h4000_1000, "rd0");
    rd(12'd2, 32'h9000_0000, "rd2");

    // backpressure: response held 5 cycles, stray write request ignored
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 12'd0;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("bp_data",  bus.rsp_rdata,          32'h4000_1000);
    held          = 32'h4000_1000;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 12'd2;
    bus.req_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("bp_hold_data",  bus.rsp_rdata,          held);
      chk("bp_req_ready",  {31'b0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_release_state", {30'b0, dbg_state},     {30'b0, S_IDLE});
    chk("bp_release_valid", {31'b0, bus.rsp_valid}, 32'd0);
    rd(12'd2, 32'h9000_0000, "rd_after_ignored_wr");

    // write then read at 0x7FF
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 12'h7FF;
    bus.req_wdata = 32'hFFFF_F800;
    exp_q.push_back(32'hFFFF_F800);
    step();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    chk("wr_valid", {31'b0, bus.rsp_valid}, 32'd1);
    held = exp_q.pop_front();
    chk("wr_echo", bus.rsp_rdata, held);
    bus.rsp_ready = 1'b1;
    step();
    chk("wr_done", {31'b0, bus.rsp_valid}, 32'd0);
    rd(12'h7FF, 32'hFFFF_F800, "rd_7ff");

    // reset while a read is pending
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 12'd1;
    step();
    bus.req_valid = 1'b0;
    chk("rdw_state", {30'b0, dbg_state}, {30'b0, S_RD_WAIT});
    reset = 1'b1;
    step();
    chk("rdw_rst_valid",      {31'b0, bus.rsp_valid},  32'd0);
    chk("rdw_rst_boot_done",  {31'b0, bus.boot_done},  32'd0);
    chk("rdw_rst_load_ready", {31'b0, bus.load_ready}, 32'd1);
    chk("rdw_rst_state",      {30'b0, dbg_state},      {30'b0, S_BOOT});
    chk("rdw_rst_rdata",      bus.rsp_rdata,           32'd0);
    reset = 1'b0;

    // full-depth boot without load_last
    bus.load_valid = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      bus.load_data = 32'hA500_0000 | 32'(i);
      step();
      if (i == 4094) chk("wrap_not_done", {31'b0, bus.boot_done}, 32'd0);
    end
    bus.load_valid = 1'b0;
    chk("wrap_done",       {31'b0, bus.boot_done},  32'd1);
    chk("wrap_load_ready", {31'b0, bus.load_ready}, 32'd0);
    rd(12'd0,   32'hA500_0000, "wrap_rd0");
    rd(12'hFFF, 32'hA500_0FFF, "wrap_rdfff");
    rd(12'h7FF, 32'hA500_07FF, "wrap_rd7ff");
    rd(12'd1,   32'hA500_0001, "wrap_rd1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
